// File: rtl/core_in_unit.sv
// IN-instruction service unit: buffers UART bytes in a small FIFO and, on an IN
// request, stalls the core until a byte is available, then writes it to the register file.
module core_in_unit #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_VALID,
  input  logic [7:0]         RX_DATA,
  output logic               RX_READY,
  input  logic               IN_REQ,
  input  logic [4:0]         IN_RD,
  output logic               IN_STALL,
  output logic               IN_DONE,
  output logic               INE,
  output logic [7:0]         INDATA,
  output logic [4:0]         INWADDR,
  output logic [FIFO_AW:0]   FIFO_COUNT,
  output logic               OVERRUN,
  input  logic               CLR_OVERRUN
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_DONE} state_t;

  localparam logic [FIFO_AW:0] DEPTH_C = FIFO_DEPTH[FIFO_AW:0];

  state_t               r_state;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [FIFO_AW:0]     r_count;
  logic [4:0]           r_rd;
  logic                 r_ine;
  logic [7:0]           r_indata;
  logic [4:0]           r_inwaddr;
  logic                 r_in_done;
  logic                 r_overrun;

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_nonempty;
  logic [7:0]           w_head;

  assign w_full     = (r_count == DEPTH_C);
  assign w_push     = RX_VALID && !w_full;
  assign w_pop      = (r_state == S_WRITE);
  assign w_nonempty = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];

  assign RX_READY   = !w_full;
  assign IN_STALL   = ((r_state == S_IDLE) && IN_REQ) || (r_state == S_WAIT) || (r_state == S_WRITE);
  assign IN_DONE    = r_in_done;
  assign INE        = r_ine;
  assign INDATA     = r_indata;
  assign INWADDR    = r_inwaddr;
  assign FIFO_COUNT = r_count;
  assign OVERRUN    = r_overrun;

  // Storage has no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= RX_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A set request wins over a clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST)                   r_overrun <= 1'b0;
    else if (RX_VALID && w_full) r_overrun <= 1'b1;
    else if (CLR_OVERRUN)      r_overrun <= 1'b0;
  end

  // Write-port outputs are loaded on the edge entering WRITE so they are registered;
  // the head cannot move before WRITE because only WRITE pops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_rd      <= '0;
      r_ine     <= 1'b0;
      r_indata  <= '0;
      r_inwaddr <= '0;
      r_in_done <= 1'b0;
    end else begin
      r_ine     <= 1'b0;
      r_indata  <= '0;
      r_inwaddr <= '0;
      r_in_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (IN_REQ) begin
            r_rd <= IN_RD;
            if (w_nonempty) begin
              r_state <= S_WRITE;
              if (IN_RD != 5'd0) begin
                r_ine     <= 1'b1;
                r_indata  <= w_head;
                r_inwaddr <= IN_RD;
              end
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_nonempty) begin
            r_state <= S_WRITE;
            if (r_rd != 5'd0) begin
              r_ine     <= 1'b1;
              r_indata  <= w_head;
              r_inwaddr <= r_rd;
            end
          end
        end
        S_WRITE: begin
          r_state   <= S_DONE;
          r_in_done <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_in_unit.sv
// Directed bench for core_in_unit: reset, buffered/empty IN, full/overrun with wrap,
// simultaneous push/pop, x0 destination and reset while waiting.
module tb_core_in_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_VALID;
  logic [7:0] RX_DATA;
  logic       RX_READY;
  logic       IN_REQ;
  logic [4:0] IN_RD;
  logic       IN_STALL;
  logic       IN_DONE;
  logic       INE;
  logic [7:0] INDATA;
  logic [4:0] INWADDR;
  logic [4:0] FIFO_COUNT;
  logic       OVERRUN;
  logic       CLR_OVERRUN;

  int checks = 0;
  int errors = 0;

  core_in_unit #(.FIFO_DEPTH(16)) dut (
    .CLK(CLK), .RST(RST), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_READY(RX_READY),
    .IN_REQ(IN_REQ), .IN_RD(IN_RD), .IN_STALL(IN_STALL), .IN_DONE(IN_DONE), .INE(INE),
    .INDATA(INDATA), .INWADDR(INWADDR), .FIFO_COUNT(FIFO_COUNT), .OVERRUN(OVERRUN),
    .CLR_OVERRUN(CLR_OVERRUN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout observed no-finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    RX_VALID = 1'b1;
    RX_DATA  = b;
    step();
    RX_VALID = 1'b0;
    #1;
  endtask

  // IN with data already buffered: WRITE in the next cycle, DONE the one after.
  task automatic do_in(input string tag, input logic [4:0] rd, input logic [7:0] data,
                       input logic ine_exp);
    IN_REQ = 1'b1;
    IN_RD  = rd;
    #1;
    chk({tag, "_stall_req"}, 32'(IN_STALL), 32'd1);
    step();
    chk({tag, "_ine"},     32'(INE),     32'(ine_exp));
    chk({tag, "_indata"},  32'(INDATA),  ine_exp ? 32'(data) : 32'd0);
    chk({tag, "_inwaddr"}, 32'(INWADDR), ine_exp ? 32'(rd) : 32'd0);
    chk({tag, "_nodone"},  32'(IN_DONE), 32'd0);
    step();
    chk({tag, "_done"},    32'(IN_DONE), 32'd1);
    chk({tag, "_ine_off"}, 32'(INE),     32'd0);
    chk({tag, "_stall_done"}, 32'(IN_STALL), 32'd0);
    IN_REQ = 1'b0;
    step();
  endtask

  initial begin
    RST = 1'b1; RX_VALID = 1'b1; RX_DATA = 8'h11; IN_REQ = 1'b0; IN_RD = '0;
    CLR_OVERRUN = 1'b0;

    // Reset held two cycles while the UART is presenting data.
    step();
    step();
    RST = 1'b0; RX_VALID = 1'b0;
    #1;
    chk("rst_count",   32'(FIFO_COUNT), 32'd0);
    chk("rst_ine",     32'(INE),        32'd0);
    chk("rst_indata",  32'(INDATA),     32'd0);
    chk("rst_inwaddr", 32'(INWADDR),    32'd0);
    chk("rst_done",    32'(IN_DONE),    32'd0);
    chk("rst_overrun", 32'(OVERRUN),    32'd0);
    chk("rst_ready",   32'(RX_READY),   32'd1);
    chk("rst_stall",   32'(IN_STALL),   32'd0);
    step();

    // Buffered IN.
    push(8'hA5);
    chk("buf_count1", 32'(FIFO_COUNT), 32'd1);
    do_in("buf", 5'd5, 8'hA5, 1'b1);
    chk("buf_count0", 32'(FIFO_COUNT), 32'd0);

    // Empty FIFO: wait 10 cycles, IN_RD changes are ignored.
    IN_REQ = 1'b1; IN_RD = 5'd3;
    step();
    IN_RD = 5'd9;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("wait_stall", 32'(IN_STALL), 32'd1);
      chk("wait_ine",   32'(INE),      32'd0);
      step();
    end
    RX_VALID = 1'b1; RX_DATA = 8'h3C;
    step();
    RX_VALID = 1'b0;
    chk("wait_ine_early", 32'(INE), 32'd0);
    step();
    chk("wait_ine",     32'(INE),     32'd1);
    chk("wait_indata",  32'(INDATA),  32'h3C);
    chk("wait_inwaddr", 32'(INWADDR), 32'd3);
    step();
    chk("wait_done", 32'(IN_DONE), 32'd1);
    IN_REQ = 1'b0;
    step();

    // Fill to full; pointers are at 2 so the write pointer wraps.
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("full_count",   32'(FIFO_COUNT), 32'd16);
    chk("full_ready",   32'(RX_READY),   32'd0);
    chk("full_ovr_pre", 32'(OVERRUN),    32'd0);
    RX_VALID = 1'b1; RX_DATA = 8'hAA;
    step();
    RX_VALID = 1'b0;
    chk("ovr_set",   32'(OVERRUN),    32'd1);
    chk("ovr_count", 32'(FIFO_COUNT), 32'd16);
    CLR_OVERRUN = 1'b1;
    step();
    CLR_OVERRUN = 1'b0;
    chk("ovr_clr", 32'(OVERRUN), 32'd0);
    RX_VALID = 1'b1; CLR_OVERRUN = 1'b1;
    step();
    RX_VALID = 1'b0; CLR_OVERRUN = 1'b0;
    chk("ovr_set_wins", 32'(OVERRUN), 32'd1);
    CLR_OVERRUN = 1'b1;
    step();
    CLR_OVERRUN = 1'b0;
    chk("ovr_clr2", 32'(OVERRUN), 32'd0);
    for (int i = 0; i < 16; i++) do_in("drain", 5'(i + 1), 8'(i), 1'b1);
    chk("drain_count", 32'(FIFO_COUNT), 32'd0);
    chk("drain_ready", 32'(RX_READY),   32'd1);

    // Push coincides with the WRITE pop.
    push(8'h11);
    IN_REQ = 1'b1; IN_RD = 5'd7;
    step();
    RX_VALID = 1'b1; RX_DATA = 8'h77;
    chk("pp_indata", 32'(INDATA), 32'h11);
    step();
    RX_VALID = 1'b0;
    chk("pp_count", 32'(FIFO_COUNT), 32'd1);
    chk("pp_done",  32'(IN_DONE),    32'd1);
    IN_REQ = 1'b0;
    step();
    do_in("pp_next", 5'd8, 8'h77, 1'b1);

    // x0 destination: byte consumed, no write.
    push(8'h5A);
    do_in("x0", 5'd0, 8'h5A, 1'b0);
    chk("x0_count", 32'(FIFO_COUNT), 32'd0);

    // Reset while waiting; then reset drops buffered bytes.
    IN_REQ = 1'b1; IN_RD = 5'd4;
    step();
    step();
    chk("midrst_wait_stall", 32'(IN_STALL), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("midrst_stall_idle", 32'(IN_STALL), 32'd1);
    IN_REQ = 1'b0;
    #1;
    chk("midrst_stall_low", 32'(IN_STALL), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_ine", 32'(INE), 32'd0);
    end
    push(8'h01);
    push(8'h02);
    chk("lost_pre", 32'(FIFO_COUNT), 32'd2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("lost_count", 32'(FIFO_COUNT), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
